// File: rtl/dsp48a1_mac_sequencer.sv
// Multiply-accumulate sequencer for one DSP48A1 slice: accepts a job length, streams
// A/B pairs into the slice, schedules OPMODE against the slice pipeline, returns the sum.
module dsp48a1_mac_sequencer #(
   parameter int DATA_W   = 18,
   parameter int ACC_W    = 48,
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_a,
   input  logic [DATA_W-1:0] s_b,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [ACC_W-1:0]  r_data,
   output logic              busy,
   output logic [DATA_W-1:0] dsp_a,
   output logic [DATA_W-1:0] dsp_b,
   output logic [7:0]        dsp_opmode,
   output logic              dsp_rst,
   input  logic [ACC_W-1:0]  dsp_p
);

   localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [7:0] OPM_LOAD = 8'h01;  // X = M, Z = 0
   localparam logic [7:0] OPM_ACC  = 8'h09;  // X = M, Z = P

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   remain, remain_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               first, first_nxt;
   logic               cap_en;
   logic [ACC_W-1:0]   cap_val;
   logic [7:0]         opmode_nxt;
   logic               accept;

   assign accept    = (state == RUN) && s_valid;
   assign cmd_ready = (state == IDLE);
   assign s_ready   = (state == RUN);
   assign r_valid   = (state == DONE);
   assign busy      = (state != IDLE);
   assign dsp_rst   = RST;

   // Bubbles feed zeros so idle cycles add a zero product to P.
   assign dsp_a = accept ? s_a : '0;
   assign dsp_b = accept ? s_b : '0;

   always_comb begin
      state_nxt  = state;
      remain_nxt = remain;
      drain_nxt  = drain_cnt;
      first_nxt  = first;
      cap_en     = 1'b0;
      cap_val    = dsp_p;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == '0) begin
                  cap_en    = 1'b1;
                  cap_val   = '0;
                  state_nxt = DONE;
               end else begin
                  remain_nxt = cmd_len;
                  first_nxt  = 1'b1;
                  state_nxt  = RUN;
               end
            end
         end
         RUN: begin
            if (accept) begin
               remain_nxt = remain - LEN_W'(1);
               first_nxt  = 1'b0;
               if (remain == LEN_W'(1)) begin
                  drain_nxt = DRAIN_W'(PIPE_LAT - 1);
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // The last product lands in P when the counter has run down to zero.
            if (drain_cnt == '0) begin
               cap_en    = 1'b1;
               state_nxt = DONE;
            end else begin
               drain_nxt = drain_cnt - DRAIN_W'(1);
            end
         end
         DONE: begin
            if (r_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // The first product of a job overwrites P instead of adding to the old sum.
      opmode_nxt = (accept && first) ? OPM_LOAD : OPM_ACC;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         remain     <= '0;
         drain_cnt  <= '0;
         first      <= 1'b0;
         r_data     <= '0;
         dsp_opmode <= OPM_ACC;
      end else begin
         state      <= state_nxt;
         remain     <= remain_nxt;
         drain_cnt  <= drain_nxt;
         first      <= first_nxt;
         dsp_opmode <= opmode_nxt;
         if (cap_en) r_data <= cap_val;
      end
   end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice model
// (A1/B1, M, OPMODE and P registers, all reset by dsp_rst).
module tb_dsp48a1_mac_sequencer;

   localparam logic [17:0] MAXV  = 18'h3FFFF;
   localparam logic [47:0] MAXSQ = 48'd68718952449;     // (2^18-1)^2
   localparam logic [47:0] WRAP  = 48'd1168222191633;   // 17*(2^18-1)^2 mod 2^48

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_len = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [17:0] s_a = '0, s_b = '0;
   logic        r_valid;
   logic        r_ready = 1'b0;
   logic [47:0] r_data;
   logic        busy;
   logic [17:0] dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_rst;
   logic [47:0] dsp_p;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int          len;
      int          first_idx;
      int          gap;
      logic [47:0] exp_sum;
   } job_t;

   job_t        jobs[5];
   logic [17:0] ta[32];
   logic [17:0] tbv[32];

   dsp48a1_mac_sequencer dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .busy(busy),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_rst(dsp_rst), .dsp_p(dsp_p)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, unsigned operands.
   logic [17:0] a1, b1;
   logic [35:0] m;
   logic [7:0]  opm_r;
   logic [47:0] p;
   always @(posedge CLK) begin
      if (dsp_rst) begin
         a1 <= '0; b1 <= '0; m <= '0; opm_r <= '0; p <= '0;
      end else begin
         a1    <= dsp_a;
         b1    <= dsp_b;
         m     <= a1 * b1;
         opm_r <= dsp_opmode;
         p     <= ((opm_r[1:0] == 2'b01) ? {12'b0, m} : 48'b0)
                + ((opm_r[3:2] == 2'b10) ? p : 48'b0);
      end
   end
   assign dsp_p = p;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input int len, input int fi, input int gap, input logic [47:0] exp);
      int c0;
      int n;
      cmd_len   = len[7:0];
      cmd_valid = 1'b1;
      #1;
      check("cmd_ready", cmd_ready, 1);
      c0 = cyc;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               s_valid = 1'b0;
               s_a = MAXV; s_b = MAXV;
               #1;
               check("dsp_a_bubble", dsp_a, 0);
               tick();
            end
         end
         s_valid = 1'b1;
         s_a = ta[fi + i];
         s_b = tbv[fi + i];
         n = 0;
         while (!s_ready && n < 20) begin
            tick();
            n++;
         end
         #1;
         check("s_ready", s_ready, 1);
         check("dsp_a_pass", dsp_a, s_a);
         check("dsp_b_pass", dsp_b, s_b);
         tick();
         if (i == 0) check("opmode_first", dsp_opmode, 8'h01);
         if (i == 1 && gap == 0) check("opmode_acc", dsp_opmode, 8'h09);
      end
      s_valid = 1'b0; s_a = '0; s_b = '0;
      n = 0;
      while (!r_valid && n < 200) begin
         tick();
         n++;
      end
      check("r_valid", r_valid, 1);
      check("latency", cyc - c0, len + 4 + gap * (len - 1));
      check("r_data", r_data, exp);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      check("busy_after", busy, 0);
      check("r_valid_after", r_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      ta[0] = 1;  tbv[0] = 2;
      ta[1] = 3;  tbv[1] = 4;
      ta[2] = 5;  tbv[2] = 6;
      ta[3] = 7;  tbv[3] = 8;
      ta[4] = 10; tbv[4] = 10;
      ta[5] = 1;  tbv[5] = 1;
      ta[6] = 2;  tbv[6] = 3;
      ta[7] = MAXV; tbv[7] = MAXV;
      ta[8] = 1;  tbv[8] = 1;
      ta[9] = 0;  tbv[9] = 5;
      for (int i = 10; i < 27; i++) begin
         ta[i] = MAXV; tbv[i] = MAXV;
      end
      ta[27] = 4; tbv[27] = 4;
      ta[28] = 3; tbv[28] = 3;

      jobs[0] = '{len: 4,  first_idx: 0,  gap: 0, exp_sum: 48'd100};
      jobs[1] = '{len: 2,  first_idx: 4,  gap: 0, exp_sum: 48'd101};
      jobs[2] = '{len: 1,  first_idx: 6,  gap: 0, exp_sum: 48'd6};
      jobs[3] = '{len: 3,  first_idx: 7,  gap: 2, exp_sum: MAXSQ + 48'd1};
      jobs[4] = '{len: 17, first_idx: 10, gap: 0, exp_sum: WRAP};

      // Reset state
      RST = 1'b1;
      tick(); tick(); tick();
      check("rst_r_valid", r_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_r_data", r_data, 0);
      check("rst_opmode", dsp_opmode, 8'h09);
      check("rst_dsp_rst", dsp_rst, 1);
      RST = 1'b0;
      tick();
      check("cmd_ready_after_rst", cmd_ready, 1);
      check("dsp_rst_low", dsp_rst, 0);

      for (int j = 0; j < 5; j++)
         run_job(jobs[j].len, jobs[j].first_idx, jobs[j].gap, jobs[j].exp_sum);

      // Zero-length job, result held under backpressure, cmd ignored outside IDLE
      begin
         int c0;
         cmd_len = 8'd0; cmd_valid = 1'b1;
         #1;
         check("len0_cmd_ready", cmd_ready, 1);
         c0 = cyc;
         tick();
         cmd_len = 8'd3;
         check("len0_r_valid", r_valid, 1);
         check("len0_latency", cyc - c0, 1);
         check("len0_r_data", r_data, 0);
         for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_r_valid", r_valid, 1);
            check("hold_r_data", r_data, 0);
            check("hold_cmd_ready", cmd_ready, 0);
         end
         cmd_valid = 1'b0;
         r_ready = 1'b1;
         tick();
         r_ready = 1'b0;
         check("len0_idle", busy, 0);
      end

      // Reset in the middle of a job
      cmd_len = 8'd5; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      s_valid = 1'b1; s_a = ta[28]; s_b = tbv[28];
      tick(); tick();
      check("mid_busy", busy, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
      check("abort_r_valid", r_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_opmode", dsp_opmode, 8'h09);
      run_job(1, 27, 0, 48'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
